// File: rtl/taglist_pkg.sv
// Shared taglist definitions: entry field positions and player state encoding.
// Both the taglist generator and any taglist reader import this package.
package taglist_pkg;

    localparam int TL_RSVD_HI  = 31;
    localparam int TL_RSVD_LO  = 28;
    localparam int TL_SEQ_HI   = 27;
    localparam int TL_SEQ_LO   = 21;
    localparam int TL_FIRST_HI = 20;
    localparam int TL_FIRST_LO = 11;
    localparam int TL_LAST_HI  = 10;
    localparam int TL_LAST_LO  = 1;
    localparam int TL_END_BIT  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_CHECK,
        ST_PLAY,
        ST_FIN
    } tl_state_e;

endpackage

// File: rtl/taglist_entry_check.sv
// Combinational unpack of one taglist entry plus its validity check against
// the sequence number the reader asked for.
module taglist_entry_check
    import taglist_pkg::*;
#(
    parameter int SEQ_W  = 7,
    parameter int ADDR_W = 10
) (
    input  logic [31:0]       entry_i,
    input  logic [SEQ_W-1:0]  exp_seq_i,
    output logic [ADDR_W-1:0] first_o,
    output logic [ADDR_W-1:0] last_o,
    output logic              end_rom_o,
    output logic              ok_o
);

    logic [TL_RSVD_HI-TL_RSVD_LO:0] rsvd;
    logic [TL_SEQ_HI-TL_SEQ_LO:0]   seq;

    always_comb begin
        rsvd      = entry_i[TL_RSVD_HI:TL_RSVD_LO];
        seq       = entry_i[TL_SEQ_HI:TL_SEQ_LO];
        first_o   = entry_i[TL_FIRST_HI:TL_FIRST_LO];
        last_o    = entry_i[TL_LAST_HI:TL_LAST_LO];
        end_rom_o = entry_i[TL_END_BIT];
        // An empty range (first > last) is malformed, not a zero-length play.
        ok_o      = (rsvd == '0) && (seq == exp_seq_i) && (first_o <= last_o);
    end

endmodule

// File: rtl/taglist_seq_player.sv
// Taglist playback controller: fetches and validates one taglist entry, then
// walks the sample ROM address from first to last under valid/ready flow control.
module taglist_seq_player
    import taglist_pkg::*;
#(
    parameter int SEQ_W   = 7,
    parameter int ADDR_W  = 10,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_1KHz,
    input  logic              reset,
    input  logic              start,
    input  logic [SEQ_W-1:0]  seq_req,
    input  logic              abort,
    output logic              ram_rd_en,
    output logic [SEQ_W-1:0]  ram_addr,
    input  logic [31:0]       ram_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_valid,
    input  logic              rom_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              last_rom
);

    tl_state_e         state_q;
    logic [1:0]        wait_q;
    logic [ADDR_W-1:0] last_q;

    logic [ADDR_W-1:0] ent_first;
    logic [ADDR_W-1:0] ent_last;
    logic              ent_end;
    logic              ent_ok;

    // ram_data is valid during CHECK; ram_addr still holds the captured seq_req.
    taglist_entry_check #(
        .SEQ_W  (SEQ_W),
        .ADDR_W (ADDR_W)
    ) u_check (
        .entry_i   (ram_data),
        .exp_seq_i (ram_addr),
        .first_o   (ent_first),
        .last_o    (ent_last),
        .end_rom_o (ent_end),
        .ok_o      (ent_ok)
    );

    always_ff @(posedge clk_1KHz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            last_q    <= '0;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
            rom_addr  <= '0;
            rom_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            last_rom  <= 1'b0;
        end else begin
            ram_rd_en <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            if (state_q != ST_IDLE && abort) begin
                state_q   <= ST_IDLE;
                rom_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            ram_addr  <= seq_req;
                            ram_rd_en <= 1'b1;
                            busy      <= 1'b1;
                            last_rom  <= 1'b0;
                            wait_q    <= 2'd1;
                            state_q   <= ST_RD;
                        end
                    end
                    // wait_q counts cycles since the read strobe was issued.
                    ST_RD, ST_WAIT: begin
                        if (wait_q == 2'(RAM_LAT)) begin
                            state_q <= ST_CHECK;
                        end else begin
                            wait_q  <= wait_q + 2'd1;
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_CHECK: begin
                        if (ent_ok) begin
                            rom_addr  <= ent_first;
                            rom_valid <= 1'b1;
                            last_rom  <= ent_end;
                            last_q    <= ent_last;
                            state_q   <= ST_PLAY;
                        end else begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    // Termination is by compare against last, so 1023 never wraps.
                    ST_PLAY: begin
                        if (rom_ready) begin
                            if (rom_addr == last_q) begin
                                rom_valid <= 1'b0;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                state_q   <= ST_FIN;
                            end else begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                            end
                        end
                    end
                    ST_FIN:  state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_taglist_seq_player.sv
// Bench for taglist_seq_player: directed scenarios plus randomized entries
// checked against an entry-level outcome model (reject, or addresses first..last).
module tb_taglist_seq_player;

    logic        clk = 1'b0;
    logic        reset, start, abort, rom_ready;
    logic [6:0]  seq_req;
    logic        ram_rd_en;
    logic [6:0]  ram_addr;
    logic [31:0] ram_data = '0;
    logic [9:0]  rom_addr;
    logic        rom_valid, busy, done, err, last_rom;

    taglist_seq_player #(.SEQ_W(7), .ADDR_W(10), .RAM_LAT(1)) dut (
        .clk_1KHz (clk),
        .reset    (reset),
        .start    (start),
        .seq_req  (seq_req),
        .abort    (abort),
        .ram_rd_en(ram_rd_en),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .rom_addr (rom_addr),
        .rom_valid(rom_valid),
        .rom_ready(rom_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .last_rom (last_rom)
    );

    always #5 clk = ~clk;

    // Taglist RAM with one cycle of read latency.
    logic [31:0] mem [128];
    always @(posedge clk) if (ram_rd_en) ram_data <= mem[ram_addr];

    // Consumer-side monitor, sampled on the falling edge.
    int         done_cnt = 0, err_cnt = 0, valid_cnt = 0, stall_err = 0;
    logic [9:0] acc_q[$];
    logic       pv = 1'b0, pr = 1'b0, pctl = 1'b0;
    logic [9:0] pa = '0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (rom_valid) valid_cnt <= valid_cnt + 1;
        if (pv && !pr && !pctl && (!rom_valid || rom_addr != pa)) stall_err <= stall_err + 1;
        if (rom_valid && rom_ready && !abort && !reset) acc_q.push_back(rom_addr);
        pv   <= rom_valid;
        pr   <= rom_ready;
        pa   <= rom_addr;
        pctl <= abort || reset;
    end

    int passes = 0, total = 0;
    int b_done, b_err, b_valid, b_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] r, input logic [6:0] s,
                                       input logic [9:0] f, input logic [9:0] l, input logic e);
        return {r, s, f, l, e};
    endfunction

    task automatic mark();
        b_done  = done_cnt;
        b_err   = err_cnt;
        b_valid = valid_cnt;
        b_acc   = acc_q.size();
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random ready
    task automatic play(input logic [6:0] req, input int mode, input bit inject);
        int k;
        bit fin;
        k = 0;
        fin = 1'b0;
        mark();
        seq_req = req;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!fin && k < 3000) begin
            case (mode)
                0:       rom_ready = 1'b1;
                1:       rom_ready = (k % 3 == 0);
                default: rom_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject && k == 6) begin
                seq_req = 7'd9;
                start   = 1'b1;
            end else begin
                start   = 1'b0;
            end
            tick();
            k++;
            if (done_cnt != b_done || err_cnt != b_err) fin = 1'b1;
        end
        start = 1'b0;
        seq_req = req;
        rom_ready = 1'b0;
        tick();
        check("run_finished", 32'(fin), 32'd1);
    endtask

    // Outcome model: reject, or exactly the addresses first..last in order.
    task automatic expect_run(input string tag, input logic [6:0] req, input logic [31:0] ent);
        bit rej;
        int f, l, n, bad;
        f   = int'(ent[20:11]);
        l   = int'(ent[10:1]);
        rej = (ent[31:28] != 4'd0) || (ent[27:21] != req) || (f > l);
        n   = rej ? 0 : (l - f + 1);
        check({tag, "_err"}, 32'(err_cnt - b_err), 32'(rej));
        check({tag, "_done"}, 32'(done_cnt - b_done), 32'(!rej));
        check({tag, "_count"}, 32'(acc_q.size() - b_acc), 32'(n));
        bad = 0;
        for (int i = 0; i < n && b_acc + i < acc_q.size(); i++)
            if (int'(acc_q[b_acc + i]) != f + i) bad++;
        check({tag, "_addr_mismatches"}, 32'(bad), 32'd0);
        if (rej) check({tag, "_valid_cycles"}, 32'(valid_cnt - b_valid), 32'd0);
        else     check({tag, "_last_rom"}, 32'(last_rom), 32'(ent[0]));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; rom_ready = 1'b0; seq_req = '0;
        for (int i = 0; i < 128; i++) mem[i] = mk(4'd0, 7'(i), 10'd7, 10'd5, 1'b0);
        mem[5]  = mk(4'd0, 7'd5, 10'd100, 10'd103, 1'b0);
        mem[9]  = mk(4'd0, 7'd9, 10'd1023, 10'd1023, 1'b1);
        mem[4]  = mk(4'd0, 7'd3, 10'd10, 10'd12, 1'b0);
        mem[10] = mk(4'd0, 7'd10, 10'd200, 10'd150, 1'b0);
        mem[11] = mk(4'd8, 7'd11, 10'd5, 10'd6, 1'b1);
        tick(); tick();
        check("rst_rd_en", 32'(ram_rd_en), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_valid", 32'(rom_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_last_rom", 32'(last_rom), 32'd0);
        reset = 1'b0;
        tick();

        // Latency and throughput with ready held high.
        mark();
        rom_ready = 1'b1; seq_req = 7'd5; start = 1'b1;
        tick(); start = 1'b0;
        check("lat_busy_rd", 32'(busy), 32'd1);
        check("lat_rd_en", 32'(ram_rd_en), 32'd1);
        check("lat_ram_addr", 32'(ram_addr), 32'd5);
        tick();
        check("lat_valid_in_check", 32'(rom_valid), 32'd0);
        tick();
        check("lat_valid_c3", 32'(rom_valid), 32'd1);
        check("lat_addr_c3", 32'(rom_addr), 32'd100);
        tick(); check("lat_addr_c4", 32'(rom_addr), 32'd101);
        tick(); check("lat_addr_c5", 32'(rom_addr), 32'd102);
        tick(); check("lat_addr_c6", 32'(rom_addr), 32'd103);
        check("lat_done_early", 32'(done), 32'd0);
        tick();
        check("lat_done", 32'(done), 32'd1);
        check("lat_valid_off", 32'(rom_valid), 32'd0);
        check("lat_busy_off", 32'(busy), 32'd0);
        tick();
        check("lat_done_pulse", 32'(done), 32'd0);
        check("lat_last_rom", 32'(last_rom), 32'd0);
        check("lat_handshakes", 32'(acc_q.size() - b_acc), 32'd4);
        rom_ready = 1'b0;

        play(7'd5, 1, 1'b0);  expect_run("stall", 7'd5, mem[5]);
        play(7'd9, 0, 1'b0);  expect_run("top1023", 7'd9, mem[9]);
        play(7'd4, 0, 1'b0);  expect_run("rej_seq", 7'd4, mem[4]);
        play(7'd10, 0, 1'b0); expect_run("rej_order", 7'd10, mem[10]);
        play(7'd11, 0, 1'b0); expect_run("rej_rsvd", 7'd11, mem[11]);
        play(7'd5, 1, 1'b1);  expect_run("start_in_play", 7'd5, mem[5]);

        // Abort while presenting address 102.
        mark();
        rom_ready = 1'b1; seq_req = 7'd5; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 20 && !(rom_valid && rom_addr == 10'd102); k++) tick();
        check("abort_at_102", 32'(rom_addr), 32'd102);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_valid", 32'(rom_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tick(); tick();
        check("abort_no_done", 32'(done_cnt - b_done), 32'd0);
        check("abort_no_err", 32'(err_cnt - b_err), 32'd0);
        play(7'd5, 0, 1'b0); expect_run("after_abort", 7'd5, mem[5]);

        // Reset mid-playback.
        mark();
        rom_ready = 1'b1; seq_req = 7'd5; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 20 && !(rom_valid && rom_addr == 10'd101); k++) tick();
        check("rstmid_at_101", 32'(rom_addr), 32'd101);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rstmid_valid", 32'(rom_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_rom_addr", 32'(rom_addr), 32'd0);
        tick(); tick();
        check("rstmid_no_done", 32'(done_cnt - b_done), 32'd0);
        check("rstmid_no_err", 32'(err_cnt - b_err), 32'd0);
        play(7'd5, 2, 1'b0); expect_run("after_reset", 7'd5, mem[5]);

        // Randomized entries and consumer back-pressure.
        for (int it = 0; it < 25; it++) begin
            logic [6:0] rq, sq;
            logic [3:0] rs;
            logic [9:0] f, l;
            int kind;
            rq   = 7'($urandom_range(0, 127));
            kind = int'($urandom_range(0, 4));
            rs   = 4'd0;
            sq   = rq;
            f    = 10'($urandom_range(0, 1023));
            l    = (f > 10'd1017) ? 10'd1023 : f + 10'($urandom_range(0, 6));
            case (kind)
                0: rs = 4'($urandom_range(1, 15));
                1: sq = rq + 7'($urandom_range(1, 127));
                2: begin
                    f = 10'($urandom_range(1, 1023));
                    l = 10'($urandom_range(0, int'(f) - 1));
                end
                default: ;
            endcase
            mem[rq] = mk(rs, sq, f, l, 1'($urandom_range(0, 1)));
            play(rq, 2, 1'b0);
            expect_run("rnd", rq, mem[rq]);
        end

        check("valid_held_under_stall", 32'(stall_err), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
